hram_port_arbiter: RTL and testbench
====================================

# hram_port_arbiter

Two-port Avalon-MM arbiter that shares the single HyperRAM memory transaction engine between a CPU requester (port 0) and a DMA requester (port 1). Accepts one access at a time with round-robin fairness and forwards it over a valid/ready command channel. It then waits for the engine's completion, returns read data to the owning port, and enforces a recovery gap between HyperRAM transactions. It sits between the system interconnect and the read/write memory sequencers, in place of direct s0 wiring.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- GAP_CYC, 8, idle clk cycles enforced after each completion (0 allowed)
- TIMEOUT, 255, max cycles in WAIT before forced completion (≥1)

Reset `rst` is synchronous and active-high; clock `clk`.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rN_address  in  ADDR_W  port N address (N = 0, 1)
- rN_read / rN_write  in  1  port N request strobes
- rN_writedata  in  DATA_W  port N write data
- rN_waitrequest  out  1  port N stall
- rN_readdata  out  DATA_W  port N read data
- rN_readdatavalid  out  1  port N read data strobe
- cmd_valid  out  1  command to engine valid
- cmd_ready  in  1  engine accepts command
- cmd_write  out  1  1 = write, 0 = read
- cmd_addr  out  ADDR_W  command address
- cmd_wdata  out  DATA_W  command write data
- rsp_done  in  1  engine completion pulse
- rsp_rdata  in  DATA_W  read data, valid with rsp_done
- err_timeout  out  1  sticky: a WAIT timed out

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE: requester N is pending if rN_read|rN_write. Grant goes to the single pending port. If both are pending, grant goes to !last_grant.
- On grant, latch address, data, direction and owner; update last_grant; go to ISSUE.
- If read and write are asserted together on one port, it is treated as a write.
- rN_waitrequest = rst | ((rN_read|rN_write) & ~(state==IDLE & grant==N)). This is combinational, so the accept cycle is the single cycle with waitrequest low. Writes are posted at accept.
- ISSUE: cmd_valid=1 with latched fields held stable. On cmd_ready, go to WAIT. No timeout applies in ISSUE.
- WAIT: on rsp_done, a read pulses the owner's readdatavalid for 1 cycle with readdata=rsp_rdata (registered). Then go to GAP, or to IDLE if GAP_CYC=0.
- WAIT timeout: after TIMEOUT cycles without rsp_done, set err_timeout. A read returns readdatavalid with readdata=0. Exit as for a normal completion.
- GAP: hold for exactly GAP_CYC cycles, then go to IDLE.
- rsp_done outside WAIT is ignored.
- Reset values: state=IDLE, last_grant=1 (port 0 wins the first tie), cmd_valid=0, readdatavalid=0, readdata=0, cmd_* fields=0, err_timeout=0.
- Reset mid-operation: any in-flight transaction is dropped and no readdatavalid is issued. err_timeout is cleared only by rst.

## Timing
- Request present at cycle 0 in IDLE: accepted at cycle 0, cmd_valid high from cycle 1.
- cmd_ready sampled high at cycle k: cmd_valid low from k+1, state WAIT.
- rsp_done at cycle n: rN_readdatavalid high at n+1. IDLE is re-entered at n+1+GAP_CYC, and the next accept can occur in that cycle.
- Minimum spacing between accepts: 3+GAP_CYC cycles (with cmd_ready and rsp_done immediate).
- Timeout: WAIT entered at w with no rsp_done → forced completion treated as if rsp_done arrived at w+TIMEOUT-1.

## Structure
- Package hram_pkg holds arb_state_t (IDLE, ISSUE, WAIT, GAP), owner_t, and default GAP/TIMEOUT constants.
- Sub-module hram_rr_arb2 is the 2-way round-robin picker: inputs req[1:0], last; outputs grant, valid; combinational.
- A single shared down-counter serves both GAP and the WAIT timeout, with width $clog2(max(GAP_CYC,TIMEOUT)+1).

## Test plan
- Single port 0 read of 0x0000_0100: cmd_addr=0x100, cmd_write=0. rsp_done with 0xCAFE_F00D → r0_readdatavalid 1 cycle later with 0xCAFE_F00D; r1 untouched.
- Port 0 and port 1 reading simultaneously from reset: port 0 is granted first, port 1 is granted next in the following IDLE. Repeating the contention alternates grants 0,1,0,1.
- Port 1 write 0x1234_5678 to 0x40: waitrequest is low exactly at the accept cycle. cmd_wdata=0x1234_5678 is held while cmd_ready=0 for 5 cycles. No readdatavalid is issued.
- GAP_CYC=8 back-to-back: the next accept occurs no earlier than rsp_done+9. With GAP_CYC=0, the accept occurs at rsp_done+1.
- TIMEOUT=16, no rsp_done for a read: err_timeout=1 and readdatavalid with 0 at WAIT+16. A late rsp_done is ignored.
- rst asserted during WAIT: the next cycle shows IDLE with cmd_valid=0 and err_timeout=0, and no readdatavalid ever appears for the dropped read.

Source files
------------

// File: rtl/hram_port_arbiter_pkg.sv
// Shared types and defaults for the HyperRAM two-port arbiter.
package hram_pkg;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t WAIT  = 2'd2;
    localparam arb_state_t GAP   = 2'd3;

    typedef logic owner_t;
    localparam owner_t OWNER_CPU = 1'b0;
    localparam owner_t OWNER_DMA = 1'b1;

    localparam int DEF_GAP_CYC = 8;
    localparam int DEF_TIMEOUT = 255;

    // One counter serves both the recovery gap and the completion timeout.
    function automatic int cnt_width(input int gap_cyc, input int timeout);
        int m;
        m = (gap_cyc > timeout) ? gap_cyc : timeout;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hram_port_arbiter_if.sv
// Requester ports, engine command/response channel and status of the arbiter.
interface hram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] r0_address;
    logic              r0_read;
    logic              r0_write;
    logic [DATA_W-1:0] r0_writedata;
    logic              r0_waitrequest;
    logic [DATA_W-1:0] r0_readdata;
    logic              r0_readdatavalid;

    logic [ADDR_W-1:0] r1_address;
    logic              r1_read;
    logic              r1_write;
    logic [DATA_W-1:0] r1_writedata;
    logic              r1_waitrequest;
    logic [DATA_W-1:0] r1_readdata;
    logic              r1_readdatavalid;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              err_timeout;

    modport master (
        input  r0_address, r0_read, r0_write, r0_writedata,
        output r0_waitrequest, r0_readdata, r0_readdatavalid,
        input  r1_address, r1_read, r1_write, r1_writedata,
        output r1_waitrequest, r1_readdata, r1_readdatavalid,
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_done, rsp_rdata,
        output err_timeout
    );

    modport slave (
        output r0_address, r0_read, r0_write, r0_writedata,
        input  r0_waitrequest, r0_readdata, r0_readdatavalid,
        output r1_address, r1_read, r1_write, r1_writedata,
        input  r1_waitrequest, r1_readdata, r1_readdatavalid,
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_done, rsp_rdata,
        input  err_timeout
    );
endinterface

// File: rtl/hram_rr_arb2.sv
// Two-way round-robin picker, purely combinational: a lone requester wins,
// a tie goes to the port that did not win last time.
module hram_rr_arb2
    import hram_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output owner_t     grant,
    output logic       valid
);
    assign valid = |req;
    assign grant = (&req) ? ~last : owner_t'(req[1]);
endmodule

// File: rtl/hram_port_arbiter.sv
// Shares one HyperRAM engine between CPU (port 0) and DMA (port 1), one access at a time;
// accept cycle is the only cycle with waitrequest low, read data returns the cycle after rsp_done.
module hram_port_arbiter
    import hram_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    hram_port_arbiter_if.master bus
);
    localparam int CNT_W = cnt_width(GAP_CYC, TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    arb_state_t        state;
    owner_t            last_grant;
    owner_t            owner;
    owner_t            grant;
    logic              grant_vld;
    logic [1:0]        req;
    logic [CNT_W-1:0]  cnt;
    logic              cmd_write_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [1:0]        rdv_q;
    logic [DATA_W-1:0] rdata_q [2];
    logic              err_q;
    logic              take0;
    logic              take1;
    logic              complete;
    logic [DATA_W-1:0] rsp_val;

    assign req = {bus.r1_read | bus.r1_write, bus.r0_read | bus.r0_write};

    hram_rr_arb2 u_rr (
        .req   (req),
        .last  (last_grant),
        .grant (grant),
        .valid (grant_vld)
    );

    assign take0 = (state == IDLE) & grant_vld & (grant == OWNER_CPU);
    assign take1 = (state == IDLE) & grant_vld & (grant == OWNER_DMA);
    assign bus.r0_waitrequest = rst | (req[0] & ~take0);
    assign bus.r1_waitrequest = rst | (req[1] & ~take1);

    // A real completion beats a timeout landing on the same cycle.
    assign complete = (state == WAIT) & (bus.rsp_done | (cnt == '0));
    assign rsp_val  = bus.rsp_done ? bus.rsp_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= OWNER_DMA;
            owner       <= OWNER_CPU;
            cnt         <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdv_q       <= 2'b00;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            err_q       <= 1'b0;
        end else begin
            rdv_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner       <= grant;
                        last_grant  <= grant;
                        cmd_write_q <= grant ? bus.r1_write     : bus.r0_write;
                        cmd_addr_q  <= grant ? bus.r1_address   : bus.r0_address;
                        cmd_wdata_q <= grant ? bus.r1_writedata : bus.r0_writedata;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        cnt   <= TMO_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (complete) begin
                        if (!cmd_write_q) begin
                            rdv_q[owner]   <= 1'b1;
                            rdata_q[owner] <= rsp_val;
                        end
                        if (!bus.rsp_done) begin
                            err_q <= 1'b1;
                        end
                        if (GAP_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid        = (state == ISSUE);
    assign bus.cmd_write        = cmd_write_q;
    assign bus.cmd_addr         = cmd_addr_q;
    assign bus.cmd_wdata        = cmd_wdata_q;
    assign bus.r0_readdatavalid = rdv_q[0];
    assign bus.r1_readdatavalid = rdv_q[1];
    assign bus.r0_readdata      = rdata_q[0];
    assign bus.r1_readdata      = rdata_q[1];
    assign bus.err_timeout      = err_q;

endmodule

// File: tb/tb_hram_port_arbiter.sv
// Bench for hram_port_arbiter: two instances (gap 8 / timeout 16 and gap 0 / timeout 3)
// compared every cycle against a timestamp-based transaction model.
module tb_hram_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GAP0 = 8;
    localparam int TO0 = 16;
    localparam int GAP1 = 0;
    localparam int TO1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    hram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    hram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GAP_CYC(GAP0), .TIMEOUT(TO0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    hram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GAP_CYC(GAP1), .TIMEOUT(TO1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));

    // Stimulus and observation arrays indexed [instance][port].
    logic          rd_i [2][2];
    logic          wr_i [2][2];
    logic [AW-1:0] ad_i [2][2];
    logic [DW-1:0] wd_i [2][2];
    logic          crdy [2];
    logic          rdone [2];
    logic [DW-1:0] rdat [2];
    logic          wq_o [2][2];
    logic          rdv_o [2][2];
    logic [DW-1:0] rdd_o [2][2];
    logic          cv_o [2];
    logic          cw_o [2];
    logic          err_o [2];
    logic [AW-1:0] ca_o [2];
    logic [DW-1:0] cd_o [2];

    assign b0.r0_read = rd_i[0][0];      assign b0.r1_read = rd_i[0][1];
    assign b0.r0_write = wr_i[0][0];     assign b0.r1_write = wr_i[0][1];
    assign b0.r0_address = ad_i[0][0];   assign b0.r1_address = ad_i[0][1];
    assign b0.r0_writedata = wd_i[0][0]; assign b0.r1_writedata = wd_i[0][1];
    assign b0.cmd_ready = crdy[0];       assign b0.rsp_done = rdone[0];
    assign b0.rsp_rdata = rdat[0];
    assign wq_o[0][0] = b0.r0_waitrequest;     assign wq_o[0][1] = b0.r1_waitrequest;
    assign rdv_o[0][0] = b0.r0_readdatavalid;  assign rdv_o[0][1] = b0.r1_readdatavalid;
    assign rdd_o[0][0] = b0.r0_readdata;       assign rdd_o[0][1] = b0.r1_readdata;
    assign cv_o[0] = b0.cmd_valid;  assign cw_o[0] = b0.cmd_write;  assign err_o[0] = b0.err_timeout;
    assign ca_o[0] = b0.cmd_addr;   assign cd_o[0] = b0.cmd_wdata;

    assign b1.r0_read = rd_i[1][0];      assign b1.r1_read = rd_i[1][1];
    assign b1.r0_write = wr_i[1][0];     assign b1.r1_write = wr_i[1][1];
    assign b1.r0_address = ad_i[1][0];   assign b1.r1_address = ad_i[1][1];
    assign b1.r0_writedata = wd_i[1][0]; assign b1.r1_writedata = wd_i[1][1];
    assign b1.cmd_ready = crdy[1];       assign b1.rsp_done = rdone[1];
    assign b1.rsp_rdata = rdat[1];
    assign wq_o[1][0] = b1.r0_waitrequest;     assign wq_o[1][1] = b1.r1_waitrequest;
    assign rdv_o[1][0] = b1.r0_readdatavalid;  assign rdv_o[1][1] = b1.r1_readdatavalid;
    assign rdd_o[1][0] = b1.r0_readdata;       assign rdd_o[1][1] = b1.r1_readdata;
    assign cv_o[1] = b1.cmd_valid;  assign cw_o[1] = b1.cmd_write;  assign err_o[1] = b1.err_timeout;
    assign ca_o[1] = b1.cmd_addr;   assign cd_o[1] = b1.cmd_wdata;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int dut_acc [2];
    int done_at [2];

    // Transaction model: busy/issued flags plus the cycles at which WAIT began and IDLE resumes.
    bit            m_busy [2];
    bit            m_iss [2];
    bit            m_last [2];
    bit            m_own [2];
    bit            m_wr [2];
    bit            m_err [2];
    int            m_idle_at [2];
    int            m_wait_at [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2];
    bit            m_rdv [2][2];
    logic [DW-1:0] m_rd [2][2];
    bit            acc_now [2][2];

    function automatic int gapv(input int i);
        return (i == 0) ? GAP0 : GAP1;
    endfunction

    function automatic int tov(input int i);
        return (i == 0) ? TO0 : TO1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        for (int i = 0; i < 2; i++) begin
            bit pend [2];
            bit idle;
            int g;
            pend[0] = rd_i[i][0] | wr_i[i][0];
            pend[1] = rd_i[i][1] | wr_i[i][1];
            idle = !m_busy[i] && (cyc >= m_idle_at[i]);
            g = -1;
            if (!rst && idle) begin
                if (pend[0] && pend[1]) g = m_last[i] ? 0 : 1;
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
            end
            if (chk_en) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("i%0d_p%0d_waitrequest", i, p), wq_o[i][p], rst || (pend[p] && g != p));
                    chk($sformatf("i%0d_p%0d_readdatavalid", i, p), rdv_o[i][p], m_rdv[i][p]);
                    chk($sformatf("i%0d_p%0d_readdata", i, p), rdd_o[i][p], m_rd[i][p]);
                    if (!rst && pend[p] && !wq_o[i][p]) dut_acc[i] = cyc;
                end
                chk($sformatf("i%0d_cmd_valid", i), cv_o[i], m_busy[i] && !m_iss[i]);
                chk($sformatf("i%0d_cmd_write", i), cw_o[i], m_wr[i]);
                chk($sformatf("i%0d_cmd_addr", i), ca_o[i], m_addr[i]);
                chk($sformatf("i%0d_cmd_wdata", i), cd_o[i], m_wd[i]);
                chk($sformatf("i%0d_err_timeout", i), err_o[i], m_err[i]);
            end
            for (int p = 0; p < 2; p++) acc_now[i][p] = (g == p);

            if (rst) begin
                m_busy[i] = 0; m_iss[i] = 0; m_idle_at[i] = cyc + 1; m_last[i] = 1;
                m_wr[i] = 0; m_addr[i] = '0; m_wd[i] = '0; m_err[i] = 0;
                for (int p = 0; p < 2; p++) begin m_rdv[i][p] = 0; m_rd[i][p] = '0; end
            end else begin
                for (int p = 0; p < 2; p++) m_rdv[i][p] = 0;
                if (g >= 0) begin
                    m_busy[i] = 1; m_iss[i] = 0; m_last[i] = (g == 1); m_own[i] = (g == 1);
                    m_wr[i] = wr_i[i][g]; m_addr[i] = ad_i[i][g]; m_wd[i] = wd_i[i][g];
                end else if (m_busy[i] && !m_iss[i]) begin
                    if (crdy[i]) begin m_iss[i] = 1; m_wait_at[i] = cyc + 1; end
                end else if (m_busy[i]) begin
                    if (rdone[i] || cyc == m_wait_at[i] + tov(i) - 1) begin
                        if (!m_wr[i]) begin
                            m_rdv[i][m_own[i]] = 1;
                            m_rd[i][m_own[i]] = rdone[i] ? rdat[i] : '0;
                        end
                        if (!rdone[i]) m_err[i] = 1;
                        m_busy[i] = 0;
                        m_idle_at[i] = cyc + 1 + gapv(i);
                    end
                end
            end
        end
    endtask

    // One clock: check/update at the falling edge, then requesters drop accepted strobes.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                if (acc_now[i][p]) begin rd_i[i][p] = 0; wr_i[i][p] = 0; end
    endtask

    task automatic serve(input int i, input int lat, input logic [31:0] d);
        int n;
        n = 0;
        while (!cv_o[i] && n < 200) begin tick(); n++; end
        chk($sformatf("i%0d_cmd_seen", i), cv_o[i], 1);
        crdy[i] = 1; tick(); crdy[i] = 0;
        repeat (lat) tick();
        rdone[i] = 1; rdat[i] = d; done_at[i] = cyc;
        tick();
        rdone[i] = 0;
    endtask

    initial begin
        int n;
        int seen;
        for (int i = 0; i < 2; i++) begin
            crdy[i] = 0; rdone[i] = 0; rdat[i] = '0;
            dut_acc[i] = 0; done_at[i] = 0;
            for (int p = 0; p < 2; p++) begin
                rd_i[i][p] = 0; wr_i[i][p] = 0; ad_i[i][p] = '0; wd_i[i][p] = '0;
            end
        end
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        chk("reset_cmd_valid", cv_o[0], 0);
        chk("reset_err", err_o[0], 0);
        chk("reset_rdv", rdv_o[0][0], 0);
        rst = 0;

        // Single port-0 read.
        rd_i[0][0] = 1; ad_i[0][0] = 32'h0000_0100;
        #1;
        chk("t1_accept_wreq", wq_o[0][0], 0);
        chk("t1_cv_at_accept", cv_o[0], 0);
        tick();
        chk("t1_cv_next", cv_o[0], 1);
        chk("t1_cmd_addr", ca_o[0], 32'h100);
        chk("t1_cmd_write", cw_o[0], 0);
        crdy[0] = 1; tick(); crdy[0] = 0;
        chk("t1_cv_after_ready", cv_o[0], 0);
        rdone[0] = 1; rdat[0] = 32'hCAFE_F00D; tick(); rdone[0] = 0;
        chk("t1_rdv", rdv_o[0][0], 1);
        chk("t1_rdata", rdd_o[0][0], 32'hCAFE_F00D);
        chk("t1_r1_rdv", rdv_o[0][1], 0);
        chk("t1_r1_rdata", rdd_o[0][1], 0);
        tick();
        chk("t1_rdv_pulse", rdv_o[0][0], 0);

        // Contention from reset alternates 0,1,0,1.
        rst = 1; tick(); rst = 0;
        for (int r = 0; r < 2; r++) begin
            rd_i[0][0] = 1; rd_i[0][1] = 1; ad_i[0][0] = 32'h200; ad_i[0][1] = 32'h300;
            serve(0, 1, 32'hA000_0000 + r);
            chk($sformatf("rr%0d_first_port0", r), rdv_o[0][0], 1);
            serve(0, 1, 32'hB000_0000 + r);
            chk($sformatf("rr%0d_second_port1", r), rdv_o[0][1], 1);
        end

        // Port-1 posted write held through engine backpressure.
        repeat (12) tick();
        wr_i[0][1] = 1; ad_i[0][1] = 32'h40; wd_i[0][1] = 32'h1234_5678;
        #1;
        chk("wr_accept_wreq", wq_o[0][1], 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wr_hold%0d_cv", k), cv_o[0], 1);
            chk($sformatf("wr_hold%0d_wdata", k), cd_o[0], 32'h1234_5678);
            chk($sformatf("wr_hold%0d_write", k), cw_o[0], 1);
            chk($sformatf("wr_hold%0d_addr", k), ca_o[0], 32'h40);
            tick();
        end
        serve(0, 0, 32'hDEAD_BEEF);
        chk("wr_no_rdv1", rdv_o[0][1], 0);
        chk("wr_no_rdv0", rdv_o[0][0], 0);

        // Accept spacing after completion: gap 8 and gap 0.
        for (int i = 0; i < 2; i++) begin
            repeat (12) tick();
            rd_i[i][0] = 1; ad_i[i][0] = 32'h500;
            serve(i, 0, 32'h1111_0000 + i);
            rd_i[i][0] = 1; ad_i[i][0] = 32'h504;
            n = 0;
            while (rd_i[i][0] && n < 50) begin tick(); n++; end
            chk($sformatf("i%0d_accept_spacing", i), dut_acc[i] - done_at[i], (i == 0) ? 9 : 1);
            serve(i, 0, 32'h2222_0000 + i);
        end

        // Timeout on instance 0 (TIMEOUT 16).
        repeat (12) tick();
        rd_i[0][0] = 1; ad_i[0][0] = 32'h600;
        n = 0;
        while (!cv_o[0] && n < 50) begin tick(); n++; end
        chk("to_cmd_seen", cv_o[0], 1);
        crdy[0] = 1; tick(); crdy[0] = 0;
        repeat (15) tick();
        chk("to_err_before", err_o[0], 0);
        chk("to_rdv_before", rdv_o[0][0], 0);
        tick();
        chk("to_err", err_o[0], 1);
        chk("to_rdv", rdv_o[0][0], 1);
        chk("to_rdata_zero", rdd_o[0][0], 0);
        rdone[0] = 1; rdat[0] = 32'h5555_AAAA; tick(); rdone[0] = 0;
        chk("late_rsp_rdv", rdv_o[0][0], 0);
        chk("late_rsp_rdata", rdd_o[0][0], 0);

        // Reset while waiting drops the read and clears the sticky error.
        repeat (12) tick();
        rd_i[0][0] = 1; ad_i[0][0] = 32'h700;
        n = 0;
        while (!cv_o[0] && n < 50) begin tick(); n++; end
        crdy[0] = 1; tick(); crdy[0] = 0;
        tick();
        rst = 1; tick(); rst = 0;
        chk("rst_wait_cv", cv_o[0], 0);
        chk("rst_wait_err", err_o[0], 0);
        seen = 0;
        rdone[0] = 1; rdat[0] = 32'h7777_7777;
        for (int k = 0; k < 30; k++) begin
            tick();
            rdone[0] = 0;
            if (rdv_o[0][0]) seen++;
        end
        chk("rst_drop_rdv_count", seen, 0);

        // Random traffic on both instances.
        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!(rd_i[i][p] | wr_i[i][p]) && $urandom_range(3) == 0) begin
                        int k;
                        k = $urandom_range(3);
                        rd_i[i][p] = (k != 1);
                        wr_i[i][p] = (k == 1) || (k == 2);
                        ad_i[i][p] = $urandom;
                        wd_i[i][p] = $urandom;
                    end
                end
                crdy[i] = ($urandom_range(2) != 0);
                rdone[i] = ($urandom_range(4) == 0);
                rdat[i] = $urandom;
            end
            rst = ($urandom_range(499) == 0);
            tick();
        end
        rst = 0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
